note_player: RTL and testbench

- Consumer end of the song reader's new_note/note_done handshake.
- Captures a note code and its duration when the song reader controller pulses new_note.
- Generates a square-wave tone for that note while counting beat strobes.
- Pulses note_done once the note's duration has elapsed, which lets the controller fetch the next note.

---
 rtl/note_pkg.sv | 34 +++
 rtl/note_player_if.sv | 13 +
 rtl/note_period_rom.sv | 19 +
 rtl/note_player.sv | 74 +++++++
 tb/tb_note_player.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared encodings, widths and the note half-period table for the note player.
package note_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PLAYING = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int NUM_NOTES = 64;

    typedef int unsigned period_table_t [NUM_NOTES];

    // Equal temperament around A4 = note 49 = 440 Hz; entry 0 is the rest.
    function automatic period_table_t build_period_table(input int unsigned clk_hz);
        period_table_t t;
        real semitone = 1.0594630943592953;
        real freq;
        t[0] = 0;
        for (int unsigned n = 1; n < NUM_NOTES; n++) begin
            freq = 440.0;
            if (n > 49) begin
                for (int unsigned k = 49; k < n; k++) freq = freq * semitone;
            end else begin
                for (int unsigned k = n; k < 49; k++) freq = freq / semitone;
            end
            t[n] = $rtoi(real'(clk_hz) / (2.0 * freq) + 0.5);
        end
        return t;
    endfunction

    localparam period_table_t NOTE_HALF_PERIOD = build_period_table(100_000_000);

endpackage

// File: rtl/note_player_if.sv
// new_note/note_done handshake between the song reader controller and the note player.
interface note_player_if;
    import note_pkg::*;

    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              note_done;

    modport master (output new_note, output note, output duration, input note_done);
    modport slave  (input new_note, input note, input duration, output note_done);

endinterface

// File: rtl/note_period_rom.sv
// Combinational lookup of the tone half-period (in clock cycles) for a note code.
module note_period_rom import note_pkg::*; #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          HALF_W = 18
) (
    input  logic [NOTE_W-1:0] note,
    output logic [HALF_W-1:0] half_period
);

    localparam period_table_t         TABLE    = build_period_table(CLK_HZ);
    localparam longint unsigned       MAX_HALF = (64'd1 << HALF_W) - 64'd1;

    // Low notes whose period does not fit HALF_W saturate rather than wrap to a random pitch.
    always_comb begin
        half_period = '1;
        if (64'(TABLE[note]) <= MAX_HALF) half_period = TABLE[note][HALF_W-1:0];
    end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: square-wave tone for the note, beat counting, note_done pulse.
module note_player import note_pkg::*; #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          HALF_W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         play,
    input  logic         beat,
    note_player_if.slave bus,
    output logic         tone_out,
    output logic         busy
);

    logic [1:0]        state;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  beat_cnt;
    logic [DUR_W-1:0]  beat_next;
    logic [HALF_W-1:0] half_period;
    logic [HALF_W-1:0] tone_cnt;
    logic              tone_en;

    note_period_rom #(.CLK_HZ(CLK_HZ), .HALF_W(HALF_W)) u_rom (
        .note        (note_q),
        .half_period (half_period)
    );

    assign beat_next     = beat_cnt + 1'b1;
    assign tone_en       = (state == PLAYING) && play && (note_q != '0);
    assign busy          = (state == PLAYING);
    assign bus.note_done = (state == DONE);

    // new_note wins over everything, so a coincident beat never counts toward the new note.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            note_q   <= '0;
            dur_q    <= '0;
            beat_cnt <= '0;
        end else if (bus.new_note) begin
            note_q   <= bus.note;
            dur_q    <= bus.duration;
            beat_cnt <= '0;
            state    <= (bus.duration == '0) ? DONE : PLAYING;
        end else begin
            case (state)
                PLAYING: begin
                    if (beat && play) begin
                        beat_cnt <= beat_next;
                        if (beat_next == dur_q) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (bus.new_note || !tone_en) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (tone_cnt == half_period - 1'b1) begin
            tone_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player, run at a 1 MHz clock so tone periods stay short.
module tb_note_player;

    logic clk = 1'b0;
    logic reset;
    logic play;
    logic beat;
    logic tone_out;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    note_player_if bus ();

    note_player #(.CLK_HZ(1_000_000), .HALF_W(18)) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .beat     (beat),
        .bus      (bus),
        .tone_out (tone_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic send_note(input logic [5:0] n, input logic [5:0] d, input logic with_beat);
        @(negedge clk);
        bus.new_note = 1'b1;
        bus.note     = n;
        bus.duration = d;
        beat         = with_beat;
        @(negedge clk);
        bus.new_note = 1'b0;
        beat         = 1'b0;
    endtask

    task automatic pulse_beat();
        @(negedge clk);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
    endtask

    task automatic watch(input int n, output int dones, output int tones);
        dones = 0;
        tones = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.note_done === 1'b1) dones++;
            if (tone_out === 1'b1) tones++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; play = 1'b0; beat = 1'b0;
        bus.new_note = 1'b0; bus.note = '0; bus.duration = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.note_done, tone_out, busy} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs: got done/tone/busy=%b want 000", {bus.note_done, tone_out, busy});
        end
        reset = 1'b1;
        play  = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.note_done, busy} !== 2'b00) begin
            bad++; $display("FAIL post_reset_idle: got done/busy=%b want 00", {bus.note_done, busy});
        end
    endtask

    task automatic test_basic();
        int d, t, dsum = 0, tsum = 0;
        send_note(6'd49, 6'd3, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        for (int b = 1; b <= 3; b++) begin
            watch(98, d, t);
            dsum += d; tsum += t;
            pulse_beat();
            total++;
            if (bus.note_done !== (b == 3)) begin
                bad++; $display("FAIL basic_done_beat%0d: got %b want %b", b, bus.note_done, (b == 3));
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
        @(negedge clk);
        total++;
        if ({bus.note_done, busy} !== 2'b00) begin
            bad++; $display("FAIL basic_after_done: got done/busy=%b want 00", {bus.note_done, busy});
        end
        total++;
        if (dsum !== 0) begin bad++; $display("FAIL basic_early_done: got %0d pulses want 0", dsum); end
        total++;
        if (tsum !== 0) begin bad++; $display("FAIL basic_tone_early: got %0d high cycles want 0", tsum); end
    endtask

    task automatic test_tone();
        int n;
        send_note(6'd49, 6'd63, 1'b0);
        n = 0;
        while (tone_out === 1'b0 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (n !== 1136) begin bad++; $display("FAIL a4_rise: got %0d cycles want 1136", n); end
        send_note(6'd61, 6'd63, 1'b0);
        total++;
        if (tone_out !== 1'b0) begin bad++; $display("FAIL new_note_tone_restart: got %b want 0", tone_out); end
        n = 0;
        while (tone_out === 1'b0 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (n !== 568) begin bad++; $display("FAIL a5_rise: got %0d cycles want 568", n); end
        n = 0;
        while (tone_out === 1'b1 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (n !== 568) begin bad++; $display("FAIL a5_fall: got %0d cycles want 568", n); end
        send_note(6'd37, 6'd63, 1'b0);
        n = 0;
        while (tone_out === 1'b0 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (n !== 2273) begin bad++; $display("FAIL a3_rise: got %0d cycles want 2273", n); end
    endtask

    task automatic test_dur0();
        send_note(6'd10, 6'd0, 1'b0);
        total++;
        if ({bus.note_done, busy, tone_out} !== 3'b100) begin
            bad++; $display("FAIL dur0_done: got done/busy/tone=%b want 100", {bus.note_done, busy, tone_out});
        end
        @(negedge clk);
        total++;
        if ({bus.note_done, busy, tone_out} !== 3'b000) begin
            bad++; $display("FAIL dur0_after: got done/busy/tone=%b want 000", {bus.note_done, busy, tone_out});
        end
    endtask

    task automatic test_rest();
        int d, t, tsum = 0;
        send_note(6'd0, 6'd2, 1'b0);
        for (int b = 1; b <= 2; b++) begin
            watch(20, d, t);
            tsum += t;
            pulse_beat();
            total++;
            if (bus.note_done !== (b == 2)) begin
                bad++; $display("FAIL rest_done_beat%0d: got %b want %b", b, bus.note_done, (b == 2));
            end
            if (tone_out === 1'b1) tsum++;
        end
        total++;
        if (tsum !== 0) begin bad++; $display("FAIL rest_tone: got %0d high cycles want 0", tsum); end
    endtask

    task automatic test_pause();
        int d, t, dsum = 0, tsum = 0;
        send_note(6'd49, 6'd4, 1'b0);
        pulse_beat();
        pulse_beat();
        watch(1200, d, t);
        total++;
        if (tone_out !== 1'b1 || d !== 0) begin
            bad++; $display("FAIL pause_pre_tone: got tone=%b dones=%0d want tone=1 dones=0", tone_out, d);
        end
        @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        total++;
        if ({tone_out, busy} !== 2'b01) begin
            bad++; $display("FAIL pause_tone_off: got tone/busy=%b want 01", {tone_out, busy});
        end
        repeat (5) begin
            pulse_beat();
            watch(3, d, t);
            dsum += d; tsum += t;
        end
        total++;
        if (dsum !== 0 || tsum !== 0) begin
            bad++; $display("FAIL pause_frozen: got dones=%0d tone_high=%0d want 0/0", dsum, tsum);
        end
        play = 1'b1;
        pulse_beat();
        total++;
        if (bus.note_done !== 1'b0) begin bad++; $display("FAIL pause_resume_beat3: got %b want 0", bus.note_done); end
        pulse_beat();
        total++;
        if (bus.note_done !== 1'b1) begin bad++; $display("FAIL pause_resume_beat4: got %b want 1", bus.note_done); end
    endtask

    task automatic test_abort();
        int d, t, dsum = 0;
        send_note(6'd49, 6'd5, 1'b0);
        repeat (2) begin
            watch(10, d, t);
            dsum += d;
            pulse_beat();
            if (bus.note_done === 1'b1) dsum++;
        end
        send_note(6'd20, 6'd1, 1'b1);
        total++;
        if ({bus.note_done, busy} !== 2'b01) begin
            bad++; $display("FAIL abort_coincident_beat: got done/busy=%b want 01", {bus.note_done, busy});
        end
        watch(10, d, t);
        dsum += d;
        total++;
        if (dsum !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dsum); end
        pulse_beat();
        total++;
        if (bus.note_done !== 1'b1) begin bad++; $display("FAIL abort_second_done: got %b want 1", bus.note_done); end
        @(negedge clk);
        total++;
        if ({bus.note_done, busy} !== 2'b00) begin
            bad++; $display("FAIL abort_single_pulse: got done/busy=%b want 00", {bus.note_done, busy});
        end
    endtask

    task automatic test_async_reset();
        int d, t, dsum = 0;
        send_note(6'd49, 6'd2, 1'b0);
        pulse_beat();
        watch(1200, d, t);
        total++;
        if ({tone_out, busy} !== 2'b11) begin
            bad++; $display("FAIL async_pre: got tone/busy=%b want 11", {tone_out, busy});
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus.note_done, tone_out, busy} !== 3'b000) begin
            bad++; $display("FAIL async_immediate: got done/tone/busy=%b want 000", {bus.note_done, tone_out, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            pulse_beat();
            watch(5, d, t);
            dsum += d;
            if (busy === 1'b1) dsum++;
        end
        total++;
        if (dsum !== 0) begin bad++; $display("FAIL async_no_done: got %0d done/busy events want 0", dsum); end
        send_note(6'd49, 6'd1, 1'b0);
        pulse_beat();
        total++;
        if (bus.note_done !== 1'b1) begin bad++; $display("FAIL async_recover: got %b want 1", bus.note_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tone();
        test_dur0();
        test_rest();
        test_pause();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
